// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit.
// MDOp encodings and default latencies, also used by the controller.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed at issue, latency by counter.
// Ports: clk, reset (sync high), Start/MDOp/ReadData1E/ReadData2E in; Busy, HI, LO out.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] ReadData1E,
  input  logic [31:0] ReadData2E,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = $clog2(max_lat(MULT_LAT, DIV_LAT) + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  md_op_e           op;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sh_hi;
  logic [31:0]      sh_lo;
  logic             commit;

  logic [63:0]      ext_a;
  logic [63:0]      ext_b;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic             div_zero;
  logic             div_ovf;
  logic [31:0]      dsr;
  logic [31:0]      q_s;
  logic [31:0]      r_s;
  logic [31:0]      q_u;
  logic [31:0]      r_u;
  logic             accept;

  assign op     = md_op_e'(MDOp);
  assign Busy   = (cnt != '0);
  assign accept = Start && !Busy;

  // Low 64 bits of a product of sign-extended operands is the signed product.
  assign ext_a  = {{32{ReadData1E[31]}}, ReadData1E};
  assign ext_b  = {{32{ReadData2E[31]}}, ReadData2E};
  assign prod_s = ext_a * ext_b;
  assign prod_u = {32'd0, ReadData1E} * {32'd0, ReadData2E};

  // Divisor forced to 1 on zero so the operator never sees /0;
  // the result is discarded via commit anyway.
  assign div_zero = (ReadData2E == 32'd0);
  assign div_ovf  = (ReadData1E == 32'h8000_0000) &&
                    (ReadData2E == 32'hFFFF_FFFF);
  assign dsr      = div_zero ? 32'd1 : ReadData2E;

  always_comb begin
    q_s = '0;
    r_s = '0;
    if (div_ovf) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end else begin
      q_s = $signed(ReadData1E) / $signed(dsr);
      r_s = $signed(ReadData1E) % $signed(dsr);
    end
  end

  assign q_u = ReadData1E / dsr;
  assign r_u = ReadData1E % dsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      HI     <= '0;
      LO     <= '0;
      sh_hi  <= '0;
      sh_lo  <= '0;
      cnt    <= '0;
      commit <= 1'b0;
    end else if (Busy) begin
      cnt <= cnt - ONE;
      if (cnt == ONE && commit) begin
        HI <= sh_hi;
        LO <= sh_lo;
      end
    end else if (accept) begin
      unique case (op)
        MD_MULT: begin
          sh_hi  <= prod_s[63:32];
          sh_lo  <= prod_s[31:0];
          cnt    <= MUL_CNT;
          commit <= 1'b1;
        end
        MD_MULTU: begin
          sh_hi  <= prod_u[63:32];
          sh_lo  <= prod_u[31:0];
          cnt    <= MUL_CNT;
          commit <= 1'b1;
        end
        MD_DIV: begin
          sh_hi  <= r_s;
          sh_lo  <= q_s;
          cnt    <= DIV_CNT;
          commit <= !div_zero;
        end
        MD_DIVU: begin
          sh_hi  <= r_u;
          sh_lo  <= q_u;
          cnt    <= DIV_CNT;
          commit <= !div_zero;
        end
        MD_MTHI: HI <= ReadData1E;
        MD_MTLO: LO <= ReadData1E;
        MD_NOP6, MD_NOP7: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, expected HI/LO
// and busy length queued at issue, checked when Busy falls.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] ReadData1E;
  logic [31:0] ReadData2E;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  int compared = 0;
  int mismatched = 0;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .MDOp       (MDOp),
    .ReadData1E (ReadData1E),
    .ReadData2E (ReadData2E),
    .Busy       (Busy),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: counts busy cycles, checks HI/LO hold while busy,
  // and pops the scoreboard when Busy falls.
  int          bcnt = 0;
  logic [31:0] hold_hi;
  logic [31:0] hold_lo;
  always @(negedge clk) begin
    if (Busy === 1'b1) begin
      if (bcnt == 0) begin
        hold_hi = HI;
        hold_lo = LO;
      end else begin
        check("hold_hi", HI, hold_hi);
        check("hold_lo", LO, hold_lo);
      end
      bcnt++;
    end else if (bcnt > 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bcnt), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_lat"}, 32'(bcnt), 32'(e.lat));
        check({e.name, "_hi"}, HI, e.hi);
        check({e.name, "_lo"}, LO, e.lo);
      end
      bcnt = 0;
    end
  end

  // Called just after a negedge; Start is sampled at the next posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    Start      = 1'b1;
    MDOp       = op;
    ReadData1E = a;
    ReadData2E = b;
    @(negedge clk);
    Start      = 1'b0;
    MDOp       = 3'd6;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l,
                      input int lat, input string nm);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.lat = lat;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (Busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (Busy !== 1'b0) check({nm, "_timeout"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    Start      = 1'b0;
    MDOp       = 3'd6;
    ReadData1E = '0;
    ReadData2E = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult");
    issue(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle("mult");

    push(32'h0000_0002, 32'hFFFF_FFFA, 5, "multu");
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle("multu");

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");

    push(32'd1, 32'd3, 10, "divu");
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle("divu");

    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    check("mt_hi", HI, 32'h11);
    check("mt_lo", LO, 32'h22);
    check("mt_busy", 32'(Busy), 32'd0);

    push(32'h11, 32'h22, 10, "div0");
    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle("div0");

    push(32'd0, 32'd12, 5, "mult_ign");
    issue(MD_MULT, 32'd3, 32'd4);
    issue(MD_MTHI, 32'h55, 32'd0);
    wait_idle("mult_ign");
    issue(MD_MTHI, 32'h55, 32'd0);
    check("b2b_hi", HI, 32'h55);
    check("b2b_lo", LO, 32'd12);

    push(32'd0, 32'd0, 4, "abort");
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);

    push(32'd0, 32'h8000_0000, 10, "div_ovf");
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    issue(MD_NOP6, 32'h1234, 32'h5678);
    check("nop_hi", HI, 32'd0);
    check("nop_lo", LO, 32'h8000_0000);
    check("nop_busy", 32'(Busy), 32'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
